// File: rtl/player_motion_ctrl.sv
// Tile-locked player motion and camera offset, advanced once per VGA frame.
// Optional run mode (double speed per tile) enabled by defining PLAYER_RUN_EN.
module player_motion_ctrl #(
  parameter int unsigned TILE_PX      = 16,
  parameter int unsigned PX_PER_FRAME = 1,
  parameter int unsigned TURN_FRAMES  = 4,
  parameter int unsigned CAM_X_INIT   = 100,
  parameter int unsigned CAM_Y_INIT   = 100,
  parameter int unsigned CAM_X_MAX    = 960,
  parameter int unsigned CAM_Y_MAX    = 720
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        VS,
  input  logic [7:0]  keycode,
`ifdef PLAYER_RUN_EN
  input  logic        run_key,
`endif
  output logic [1:0]  Direction,
  output logic        Character_Moving,
  output logic [1:0]  step_phase,
  output logic [10:0] cam_x,
  output logic [10:0] cam_y,
  output logic        frame_tick
);

  localparam int unsigned CAM_W     = 11;
  localparam int unsigned CNT_W     = $clog2(TILE_PX + 1);
  localparam int unsigned TURN_W    = $clog2(TURN_FRAMES + 1);
  localparam int unsigned TURN_LAST = (TURN_FRAMES >= 2) ? TURN_FRAMES - 2 : 0;
  localparam int unsigned HALF      = TILE_PX / 2;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {IDLE, TURN, WALK} state_t;

  state_t             state_q, state_d;
  logic               vs_s1, vs_s2, vs_s3;
  logic [1:0]         dir_q, dir_d;
  logic [CAM_W-1:0]   cam_x_q, cam_x_d, cam_y_q, cam_y_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d, base;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic               parity_q, parity_d;
  logic               moving_q, moving_d;
  logic [1:0]         phase_q, phase_d;
  logic [CAM_W-1:0]   step_px;
  logic               key_vld, same_key, can_go, tile_done, new_tile, step_en;
  logic [1:0]         key_dir;
`ifdef PLAYER_RUN_EN
  logic               run_q, run_d;
`endif

  // True when a full tile in direction d would push the camera out of range.
  function automatic logic blocked_f(input logic [1:0] d, input logic [CAM_W-1:0] x,
                                     input logic [CAM_W-1:0] y);
    logic b;
    b = 1'b0;
    case (d)
      DIR_UP:    b = (y < CAM_W'(TILE_PX));
      DIR_RIGHT: b = (({1'b0, x} + 12'(TILE_PX)) > 12'(CAM_X_MAX));
      DIR_DOWN:  b = (({1'b0, y} + 12'(TILE_PX)) > 12'(CAM_Y_MAX));
      default:   b = (x < CAM_W'(TILE_PX));
    endcase
    return b;
  endfunction

  // VS synchroniser and rising-edge pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vs_s1      <= 1'b0;
      vs_s2      <= 1'b0;
      vs_s3      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_s1      <= VS;
      vs_s2      <= vs_s1;
      vs_s3      <= vs_s2;
      frame_tick <= vs_s2 & ~vs_s3;
    end
  end

  // Keycode decode; unlisted codes are treated as no key.
  always_comb begin
    key_vld = 1'b1;
    key_dir = DIR_UP;
    case (keycode)
      8'h1A:   key_dir = DIR_UP;
      8'h07:   key_dir = DIR_RIGHT;
      8'h16:   key_dir = DIR_DOWN;
      8'h04:   key_dir = DIR_LEFT;
      default: key_vld = 1'b0;
    endcase
  end

  assign same_key  = key_vld && (key_dir == dir_q);
  assign can_go    = same_key && !blocked_f(dir_q, cam_x_q, cam_y_q);
  assign tile_done = (pix_cnt_q == CNT_W'(TILE_PX));
  assign new_tile  = frame_tick && can_go &&
                     ((state_q == IDLE) || ((state_q == WALK) && tile_done));
  assign step_en   = new_tile || (frame_tick && (state_q == WALK) && !tile_done);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (key_vld && !same_key) state_d = TURN;
          else if (can_go)          state_d = WALK;
        end
        TURN: if (turn_q >= TURN_W'(TURN_LAST)) state_d = IDLE;
        WALK: if (tile_done && !can_go)         state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: facing, camera, counters and sprite phase.
  always_comb begin
    dir_d     = dir_q;
    cam_x_d   = cam_x_q;
    cam_y_d   = cam_y_q;
    pix_cnt_d = pix_cnt_q;
    turn_d    = turn_q;
    parity_d  = parity_q;
    moving_d  = moving_q;
    phase_d   = phase_q;
    base      = new_tile ? '0 : pix_cnt_q;
`ifdef PLAYER_RUN_EN
    run_d     = new_tile ? run_key : run_q;
    step_px   = run_d ? CAM_W'(2 * PX_PER_FRAME) : CAM_W'(PX_PER_FRAME);
`else
    step_px   = CAM_W'(PX_PER_FRAME);
`endif
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (!key_vld) begin
            parity_d = 1'b0;
          end else if (!same_key) begin
            dir_d  = key_dir;
            turn_d = '0;
          end
        end
        TURN:    turn_d = turn_q + TURN_W'(1);
        WALK:    if (tile_done) parity_d = ~parity_q;
        default: ;
      endcase
      if (step_en) begin
        pix_cnt_d = base + CNT_W'(step_px);
        case (dir_q)
          DIR_UP:    cam_y_d = cam_y_q - step_px;
          DIR_RIGHT: cam_x_d = cam_x_q + step_px;
          DIR_DOWN:  cam_y_d = cam_y_q + step_px;
          default:   cam_x_d = cam_x_q - step_px;
        endcase
      end
      moving_d = (state_d == WALK);
      if (state_d == WALK)
        phase_d = (base < CNT_W'(HALF)) ? (parity_d ? 2'd3 : 2'd1)
                                        : (parity_d ? 2'd2 : 2'd0);
      else
        phase_d = 2'd0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      dir_q     <= DIR_DOWN;
      cam_x_q   <= CAM_W'(CAM_X_INIT);
      cam_y_q   <= CAM_W'(CAM_Y_INIT);
      pix_cnt_q <= '0;
      turn_q    <= '0;
      parity_q  <= 1'b0;
      moving_q  <= 1'b0;
      phase_q   <= 2'd0;
`ifdef PLAYER_RUN_EN
      run_q     <= 1'b0;
`endif
    end else begin
      dir_q     <= dir_d;
      cam_x_q   <= cam_x_d;
      cam_y_q   <= cam_y_d;
      pix_cnt_q <= pix_cnt_d;
      turn_q    <= turn_d;
      parity_q  <= parity_d;
      moving_q  <= moving_d;
      phase_q   <= phase_d;
`ifdef PLAYER_RUN_EN
      run_q     <= run_d;
`endif
    end
  end

  assign Direction        = dir_q;
  assign Character_Moving = moving_q;
  assign step_phase       = phase_q;
  assign cam_x            = cam_x_q;
  assign cam_y            = cam_y_q;

endmodule
